// File: rtl/vend_dec_pkg.sv
// Shared types and helpers for the vending select decoder.
package vend_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Width of the hold counter. It holds values 0..PULSE_CYC-1 and is never
  // narrower than one bit, so PULSE_CYC=1 still has a usable counter.
  function automatic int cnt_width(input int pulse_cyc);
    return (pulse_cyc <= 1) ? 1 : $clog2(pulse_cyc);
  endfunction

endpackage

// File: rtl/vend_onehot_dec.sv
// Combinational binary-to-one-hot decoder. Indices >= NUM_OUT decode to all-zero,
// so a zero result doubles as the out-of-range indication.
module vend_onehot_dec #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_OUT-1:0] onehot
);

  // One comparator per output line; only lines that exist are generated.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_line
    assign onehot[i] = (idx == SEL_W'(i));
  end

endmodule

// File: rtl/vend_select_decoder.sv
// Registered one-hot product select with programmable pulse width and a
// guaranteed all-zero gap cycle between selections.
// Build option: define SOLD_OUT_MASK_EN to let sold_out block indices;
// otherwise sold_out is present but ignored.
module vend_select_decoder
  import vend_dec_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int PULSE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic [NUM_OUT-1:0] sold_out,
  output logic [NUM_OUT-1:0] sel_onehot,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int             CNT_W    = cnt_width(PULSE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_OUT-1:0]   sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [NUM_OUT-1:0]   dec_vec;
  logic [NUM_OUT-1:0]   avail_vec;

  vend_onehot_dec #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .idx    (req_sel),
    .onehot (dec_vec)
  );

`ifdef SOLD_OUT_MASK_EN
  // A sold-out slot removes its line, which makes the request look out of range.
  assign avail_vec = dec_vec & ~sold_out;
`else
  logic unused_sold_out;
  assign unused_sold_out = ^sold_out;
  assign avail_vec       = dec_vec;
`endif

  assign req_ready  = (state_q == IDLE);
  assign sel_onehot = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Next-state logic: the decoded one-hot is latched at the handshake, so the
  // index and mask are not looked at again for the rest of the dispense.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (|avail_vec) begin
            state_d = DRIVE;
            cnt_d   = CNT_LOAD;
            sel_d   = avail_vec;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          sel_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any dispense and drops a pending err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
